// File: rtl/sbm_pkg.sv
// Shared constants and FSM state encoding for the SBM multiplier result path.
package sbm_pkg;

  localparam int SIZEC_DEF = 12176;
  localparam int WORD_DEF  = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SEND = 2'd1;
  localparam state_t DONE = 2'd2;

  // Counter width for n items, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sbm_result_serializer.sv
// Captures a full-width SBM product and streams it out LSW first over a valid/ready port.
// Optional macro SBM_SER_PARITY_EN adds a dout_par even-parity output.
module sbm_result_serializer
  import sbm_pkg::*;
#(
  parameter int SIZEC = SIZEC_DEF,
  parameter int WORD  = WORD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZEC-1:0] c_in,
  input  logic             c_valid,
  output logic             c_ready,
  output logic [WORD-1:0]  dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy
`ifdef SBM_SER_PARITY_EN
  ,
  output logic             dout_par
`endif
);

  localparam int NWORDS = (SIZEC + WORD - 1) / WORD;
  localparam int CW     = cnt_width(NWORDS);
  localparam int PADW   = NWORDS * WORD;
  localparam logic [CW-1:0] LAST_K = CW'(NWORDS - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic [PADW-1:0] cap_r;
  logic [PADW-1:0] cap_nxt_s;
  logic [WORD-1:0] word_nxt_s;
  logic            hs_s;

  logic [WORD-1:0] dout_r;
  logic            dout_valid_r;
  logic            dout_last_r;
  logic            busy_r;
  logic            c_ready_r;

  // Next-state, counter and capture selection; outputs are registered from these
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cap_nxt_s   = cap_r;
    hs_s        = dout_valid_r & dout_ready;
    case (state_r)
      IDLE: begin
        if (c_valid) begin
          cap_nxt_s   = PADW'(c_in);
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          if (cnt_r == LAST_K) begin
            state_nxt_s = DONE;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end else begin
          state_nxt_s = SEND;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Padding above SIZEC is zero, so the top word reads 0 in the unused bits
    word_nxt_s = cap_nxt_s[int'(cnt_nxt_s) * WORD +: WORD];
  end

`ifdef SBM_SER_PARITY_EN
  logic dout_par_r;

  function automatic logic word_parity(input logic [WORD-1:0] w);
    return ^w;
  endfunction
`endif

  // State, capture register and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      cap_r        <= {PADW{1'b0}};
      dout_r       <= {WORD{1'b0}};
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      c_ready_r    <= 1'b1;
`ifdef SBM_SER_PARITY_EN
      dout_par_r   <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      cap_r        <= cap_nxt_s;
      dout_r       <= (state_nxt_s == SEND) ? word_nxt_s : {WORD{1'b0}};
      dout_valid_r <= (state_nxt_s == SEND);
      dout_last_r  <= (state_nxt_s == SEND) && (cnt_nxt_s == LAST_K);
      busy_r       <= (state_nxt_s == SEND) || (state_nxt_s == DONE);
      c_ready_r    <= (state_nxt_s == IDLE);
`ifdef SBM_SER_PARITY_EN
      dout_par_r   <= (state_nxt_s == SEND) ? word_parity(word_nxt_s) : 1'b0;
`endif
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;
  assign busy       = busy_r;
  assign c_ready    = c_ready_r;
`ifdef SBM_SER_PARITY_EN
  assign dout_par   = dout_par_r;
`endif

endmodule

// File: tb/tb_sbm_result_serializer.sv
// Randomized self-checking bench for sbm_result_serializer against a shift-based word model.
module tb_sbm_result_serializer;
  import sbm_pkg::*;

  localparam int SIZEC = SIZEC_DEF;
  localparam int WORD  = WORD_DEF;
  localparam int NW    = (SIZEC + WORD - 1) / WORD;

  logic             clk = 1'b0;
  logic             rst;
  logic [SIZEC-1:0] c_in;
  logic             c_valid;
  logic             c_ready;
  logic [WORD-1:0]  dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             busy;
`ifdef SBM_SER_PARITY_EN
  logic             dout_par;
`endif

  int total = 0;
  int bad   = 0;

  logic [WORD-1:0] got_q[$];
  int  last_cnt;
  int  last_at;
  int  stall_err;
  int  busy_cyc;
  int  cr_busy_err;
  bit  timeout;
  bit  first_valid;

  always #5 clk = ~clk;

  sbm_result_serializer #(.SIZEC(SIZEC), .WORD(WORD)) dut (
    .clk        (clk),
    .rst        (rst),
    .c_in       (c_in),
    .c_valid    (c_valid),
    .c_ready    (c_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
`ifdef SBM_SER_PARITY_EN
    ,
    .dout_par   (dout_par)
`endif
  );

  // Word k of a product is simply the product shifted down by k words
  function automatic logic [WORD-1:0] model_word(input logic [SIZEC-1:0] p, input int k);
    logic [SIZEC-1:0] t;
    t = p >> (k * WORD);
    return t[WORD-1:0];
  endfunction

  function automatic logic [SIZEC-1:0] rand_prod();
    logic [SIZEC-1:0] p;
    p = '0;
    for (int i = 0; i < (SIZEC + 31) / 32; i++) p = (p << 32) | SIZEC'($urandom);
    return p;
  endfunction

  function automatic int word_errors(input logic [SIZEC-1:0] p);
    int e;
    e = 0;
    for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== model_word(p, k)) e++;
    return e;
  endfunction

  // Offer a product at a negedge and return at the negedge after it is taken
  task automatic capture(input logic [SIZEC-1:0] p);
    int n;
    n = 0;
    c_in    = p;
    c_valid = 1'b1;
    while (c_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL capture_wait c_ready=%b required=1", c_ready);
    end
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  // Drive dout_ready per mode and record handshaken words until busy drops (or stop_at words)
  task automatic collect(input int mode, input int stop_at, input bit churn);
    logic [WORD-1:0] prev_d;
    bit prev_stall;
    prev_stall  = 1'b0;
    prev_d      = '0;
    got_q.delete();
    last_cnt    = 0;
    last_at     = -1;
    stall_err   = 0;
    busy_cyc    = 0;
    cr_busy_err = 0;
    timeout     = 1'b1;
    first_valid = dout_valid;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (churn) c_in = rand_prod();
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = (cyc % 2 == 0);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && (dout_valid !== 1'b1 || dout !== prev_d)) stall_err++;
      if (busy === 1'b1) busy_cyc++;
      if (busy === 1'b1 && c_ready === 1'b1) cr_busy_err++;
      if (busy !== 1'b1 && got_q.size() > 0) begin
        timeout = 1'b0;
        break;
      end
      if (stop_at >= 0 && got_q.size() == stop_at) begin
        timeout = 1'b0;
        break;
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
        if (dout_last === 1'b1) begin
          last_cnt++;
          last_at = got_q.size();
        end
        got_q.push_back(dout);
      end
      prev_stall = (dout_valid === 1'b1) && (dout_ready !== 1'b1);
      prev_d     = dout;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; c_valid = 1'b0; dout_ready = 1'b0; c_in = '0;
    repeat (2) @(negedge clk);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout_valid got=%b required=0", dout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", busy); end
    total++; if (dout !== '0) begin bad++; $display("FAIL rst_dout got=%h required=0", dout); end
    total++; if (dout_last !== 1'b0) begin bad++; $display("FAIL rst_dout_last got=%b required=0", dout_last); end
`ifdef SBM_SER_PARITY_EN
    total++; if (dout_par !== 1'b0) begin bad++; $display("FAIL rst_dout_par got=%b required=0", dout_par); end
`endif
    rst = 1'b0;
    @(negedge clk);
    total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL rst_c_ready got=%b required=1", c_ready); end
  endtask

  task automatic test_one();
    logic [SIZEC-1:0] p;
    p = SIZEC'(1);
    capture(p);
    collect(0, -1, 1'b0);
    total++; if (timeout) begin bad++; $display("FAIL one_timeout got=1 required=0"); end
    total++; if (first_valid !== 1'b1) begin bad++; $display("FAIL one_latency dout_valid=%b required=1", first_valid); end
    total++; if (got_q.size() != NW) begin bad++; $display("FAIL one_count got=%0d required=%0d", got_q.size(), NW); end
    total++; if (word_errors(p) != 0) begin bad++; $display("FAIL one_words errors=%0d required=0", word_errors(p)); end
    total++; if (got_q.size() > 0 && got_q[0] !== 64'h1) begin bad++; $display("FAIL one_word0 got=%h required=1", got_q[0]); end
    total++; if (last_cnt != 1 || last_at != NW - 1) begin bad++; $display("FAIL one_last count=%0d at=%0d required 1 at %0d", last_cnt, last_at, NW - 1); end
    total++; if (busy_cyc != NW + 1) begin bad++; $display("FAIL one_busy_cycles got=%0d required=%0d", busy_cyc, NW + 1); end
    total++; if (cr_busy_err != 0) begin bad++; $display("FAIL one_c_ready_busy got=%0d required=0", cr_busy_err); end
    total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL one_c_ready_after got=%b required=1", c_ready); end
  endtask

  task automatic test_all_ones();
    logic [SIZEC-1:0] p;
    p = '1;
    capture(p);
    collect(0, -1, 1'b0);
    total++; if (timeout || got_q.size() != NW) begin bad++; $display("FAIL ones_count got=%0d required=%0d", got_q.size(), NW); end
    total++; if (word_errors(p) != 0) begin bad++; $display("FAIL ones_words errors=%0d required=0", word_errors(p)); end
    total++; if (got_q.size() == NW && got_q[NW-1] !== 64'h000000000000FFFF) begin bad++; $display("FAIL ones_top got=%h required=000000000000ffff", got_q[NW-1]); end
    total++; if (last_cnt != 1 || last_at != NW - 1) begin bad++; $display("FAIL ones_last count=%0d at=%0d required 1 at %0d", last_cnt, last_at, NW - 1); end
  endtask

  task automatic test_stall_toggle();
    logic [SIZEC-1:0] p;
    p = rand_prod();
    capture(p);
    collect(1, -1, 1'b0);
    total++; if (timeout || got_q.size() != NW) begin bad++; $display("FAIL toggle_count got=%0d required=%0d", got_q.size(), NW); end
    total++; if (word_errors(p) != 0) begin bad++; $display("FAIL toggle_words errors=%0d required=0", word_errors(p)); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL toggle_stable errors=%0d required=0", stall_err); end
    total++; if (busy_cyc != 2 * NW) begin bad++; $display("FAIL toggle_cycles got=%0d required=%0d", busy_cyc, 2 * NW); end
  endtask

  task automatic test_random_ready();
    logic [SIZEC-1:0] p;
    for (int r = 0; r < 2; r++) begin
      p = rand_prod();
      capture(p);
      collect(2, -1, 1'b0);
      total++; if (timeout || got_q.size() != NW) begin bad++; $display("FAIL rand_count got=%0d required=%0d", got_q.size(), NW); end
      total++; if (word_errors(p) != 0) begin bad++; $display("FAIL rand_words errors=%0d required=0", word_errors(p)); end
      total++; if (stall_err != 0) begin bad++; $display("FAIL rand_stable errors=%0d required=0", stall_err); end
      total++; if (last_cnt != 1 || last_at != NW - 1) begin bad++; $display("FAIL rand_last count=%0d at=%0d required 1 at %0d", last_cnt, last_at, NW - 1); end
    end
  endtask

  task automatic test_cvalid_held();
    logic [SIZEC-1:0] p1;
    logic [SIZEC-1:0] p2;
    p1 = rand_prod();
    p2 = rand_prod();
    c_in = p1;
    c_valid = 1'b1;
    @(negedge clk);
    collect(0, -1, 1'b1);
    total++; if (timeout || got_q.size() != NW) begin bad++; $display("FAIL held_count got=%0d required=%0d", got_q.size(), NW); end
    total++; if (word_errors(p1) != 0) begin bad++; $display("FAIL held_words errors=%0d required=0", word_errors(p1)); end
    total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL held_c_ready got=%b required=1", c_ready); end
    c_in = p2;
    @(negedge clk);
    c_valid = 1'b0;
    total++; if (dout_valid !== 1'b1 || dout !== model_word(p2, 0)) begin bad++; $display("FAIL held_second valid=%b dout=%h required 1 %h", dout_valid, dout, model_word(p2, 0)); end
    total++; if (c_ready !== 1'b0) begin bad++; $display("FAIL held_second_c_ready got=%b required=0", c_ready); end
    collect(0, -1, 1'b0);
    total++; if (got_q.size() != NW || word_errors(p2) != 0) begin bad++; $display("FAIL held_second_words count=%0d errors=%0d required %0d 0", got_q.size(), word_errors(p2), NW); end
  endtask

  task automatic test_reset_mid();
    logic [SIZEC-1:0] p;
    p = rand_prod();
    capture(p);
    collect(0, 50, 1'b0);
    total++; if (got_q.size() != 50) begin bad++; $display("FAIL mid_reach got=%0d required=50", got_q.size()); end
    #2 rst = 1'b1;
    #1;
    total++; if (dout_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst valid=%b busy=%b required 0 0", dout_valid, busy); end
    total++; if (dout !== '0 || dout_last !== 1'b0) begin bad++; $display("FAIL mid_rst_dout dout=%h last=%b required 0 0", dout, dout_last); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (c_ready !== 1'b1) begin bad++; $display("FAIL mid_c_ready got=%b required=1", c_ready); end
    p = rand_prod();
    capture(p);
    collect(0, -1, 1'b0);
    total++; if (got_q.size() != NW || word_errors(p) != 0) begin bad++; $display("FAIL mid_restart count=%0d errors=%0d required %0d 0", got_q.size(), word_errors(p), NW); end
  endtask

`ifdef SBM_SER_PARITY_EN
  task automatic test_parity();
    capture(SIZEC'(3));
    total++; if (dout_valid !== 1'b1 || dout_par !== 1'b0) begin bad++; $display("FAIL par_3 valid=%b par=%b required 1 0", dout_valid, dout_par); end
    collect(0, -1, 1'b0);
    capture(SIZEC'(7));
    total++; if (dout_valid !== 1'b1 || dout_par !== 1'b1) begin bad++; $display("FAIL par_7 valid=%b par=%b required 1 1", dout_valid, dout_par); end
    collect(0, -1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_one();
    test_all_ones();
    test_stall_toggle();
    test_random_ready();
    test_cvalid_held();
    test_reset_mid();
`ifdef SBM_SER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbm_result_serializer.md
SBM_RESULT_SERIALIZER -- requirements
Module: sbm_result_serializer

Interface
REQ-001 SHALL have parameter SIZEC, default 12176, product width in bits (matches the 6088x6088 digit-serial multiplier output).
REQ-002 SHALL have parameter WORD, default 64, output word width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port c_in, input, SIZEC, full-width product from the multiplier.
REQ-006 SHALL have port c_valid, input, 1, c_in holds a finished product.
REQ-007 SHALL have port c_ready, output, 1, the block can capture a product.
REQ-008 SHALL have port dout, output, WORD, current output word.
REQ-009 SHALL have port dout_valid, output, 1, dout is valid.
REQ-010 SHALL have port dout_ready, input, 1, downstream accepts dout.
REQ-011 SHALL have port dout_last, output, 1, the current word is the final word of the product.
REQ-012 SHALL have port busy, output, 1, a product is held and not fully sent.

Function
REQ-013 SHALL define NWORDS = ceil(SIZEC/WORD), which is 191 for the defaults, and SHALL size the word counter to clog2(NWORDS).
REQ-014 SHALL implement states IDLE, SEND and DONE.
REQ-015 SHALL drive c_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE, when c_valid=1, capture c_in into an internal SIZEC register, clear the word counter and go to SEND on the same edge.
REQ-017 SHALL, in SEND, drive dout_valid=1 and set dout to word[k] = captured bits [k*WORD +: WORD], least-significant word first; bits above SIZEC-1 SHALL read 0.
REQ-018 SHALL advance k on every cycle where dout_valid and dout_ready are both 1; dout SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-019 SHALL drive dout_last=1 exactly when k = NWORDS-1 and in SEND.
REQ-020 SHALL go to DONE on the handshake of the last word, then go to IDLE on the next cycle. The minimum gap is 1 idle cycle from the last word to the next c_ready=1.
REQ-021 SHALL drive busy=1 in SEND and DONE.
REQ-022 SHALL ignore c_valid in SEND and DONE; the captured data SHALL NOT change.
REQ-023 SHALL produce first-word latency of 1 cycle: dout_valid rises the cycle after capture.
REQ-024 SHALL, with dout_ready held at 1, transfer one word per cycle, for a total of NWORDS cycles.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-transfer, immediately set state=IDLE, counter=0, dout=0, dout_valid=0, dout_last=0, busy=0 and the captured register=0.
REQ-026 SHALL drive c_ready=1 in the first cycle after rst is released.

Configuration
REQ-027 SHALL, with macro SBM_SER_PARITY_EN defined, add an output dout_par (1 bit) that equals the XOR of dout, is valid with dout_valid, and is 0 in reset.
REQ-028 SHALL, without SBM_SER_PARITY_EN, omit the dout_par port and all its logic.

Structure
REQ-029 SHALL take the state typedef (IDLE/SEND/DONE) and the default SIZEC and WORD constants from the shared package sbm_pkg.
REQ-030 SHALL have no sub-module; the word select is an indexed part-select on the padded capture register.

Verification
REQ-031 Reset then c_valid=1 with c_in=1 -> word0=1, words1..190=0, dout_last on word 190, 191 handshakes total.
REQ-032 c_in with all bits 1 -> words 0..189=all ones, word190=0x000000000000FFFF, dout_last=1 on it only.
REQ-033 dout_ready toggling 1,0,1,0 -> each word appears exactly once and dout is stable during stalls; transfer ends after 382 cycles.
REQ-034 c_valid held at 1 with a changing c_in during SEND -> output equals the first captured product; second capture occurs 1 cycle after DONE.
REQ-035 rst pulsed at word 50 -> dout_valid=0 and busy=0 immediately; c_ready=1 next cycle; a new product starts again at word 0.
REQ-036 SBM_SER_PARITY_EN with word0=0x3 -> dout_par=0; with word0=0x7 -> dout_par=1.
